rvx_uart_tx_buffer: RTL and testbench



---
 rtl/rvx_uart_tx_buffer_pkg.sv | 26 ++
 rtl/rvx_uart_tx_buffer_sync_fifo.sv | 46 ++++
 rtl/rvx_uart_tx_buffer.sv | 161 ++++++++++++++++
 tb/tb_rvx_uart_tx_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_uart_tx_buffer_pkg.sv
// Shared constants for the UART TX buffer: slave register map, UART register map, drain FSM states.
package rvx_uart_tx_buffer_pkg;

  localparam logic [4:0] RVX_UART_WRITE_REG_ADDR        = 5'h00;
  localparam logic [4:0] RVX_UART_READ_REG_ADDR         = 5'h04;
  localparam logic [4:0] RVX_UART_STATUS_REG_ADDR       = 5'h08;

  localparam logic [4:0] RVX_UART_TXBUF_DATA_REG_ADDR   = 5'h00;
  localparam logic [4:0] RVX_UART_TXBUF_STATUS_REG_ADDR = 5'h04;
  localparam logic [4:0] RVX_UART_TXBUF_CTRL_REG_ADDR   = 5'h08;
  localparam logic [4:0] RVX_UART_TXBUF_THRESH_REG_ADDR = 5'h0C;

  typedef enum logic [2:0] {
    TXB_IDLE        = 3'd0,
    TXB_POLL        = 3'd1,
    TXB_WAIT_STATUS = 3'd2,
    TXB_WRITE       = 3'd3,
    TXB_WAIT_WRITE  = 3'd4
  } txb_state_e;

  function automatic logic [31:0] txb_status(input logic empty, input logic full,
                                             input logic ovf, input logic [7:0] level);
    return {16'h0, level, 5'h0, ovf, full, empty};
  endfunction

endpackage

// File: rtl/rvx_uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with flush; a push to a full FIFO is dropped even when a pop happens alongside.
module rvx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = level_o == (AW+1)'(DEPTH);
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Flush wins over both push and pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rvx_uart_tx_buffer.sv
// Byte FIFO in front of the UART with a drain FSM that polls UART status and writes when idle.
// Optional low-watermark interrupt and THRESH register: define RVX_UART_TXBUF_IRQ_EN.
module rvx_uart_tx_buffer
  import rvx_uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic        write_request,
  output logic        write_response,
  output logic [4:0]  uart_rw_address,
  input  logic [31:0] uart_read_data,
  output logic        uart_read_request,
  input  logic        uart_read_response,
  output logic [31:0] uart_write_data,
  output logic        uart_write_request,
  input  logic        uart_write_response,
  output logic        txbuf_irq
);

  txb_state_e         state_q, state_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               read_resp_q, write_resp_q;
  logic               overflow_q, enable_q;
  logic               data_wr, status_wr, ctrl_wr, flush, pop;
  logic               fifo_full, fifo_empty;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         head;
  logic               unused_bits;

  assign unused_bits = ^{write_data[31:8], uart_read_data[31:1]};

  assign data_wr   = write_request && rw_address == RVX_UART_TXBUF_DATA_REG_ADDR;
  assign status_wr = write_request && rw_address == RVX_UART_TXBUF_STATUS_REG_ADDR;
  assign ctrl_wr   = write_request && rw_address == RVX_UART_TXBUF_CTRL_REG_ADDR;
  assign flush     = ctrl_wr && write_data[1];
  assign pop       = state_q == TXB_WRITE;

  rvx_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (data_wr),
    .data_i  (write_data[7:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level),
    .head_o  (head)
  );

`ifdef RVX_UART_TXBUF_IRQ_EN
  logic [7:0] thresh_q;
  logic       irq_q;
  logic       thresh_wr;

  assign thresh_wr = write_request && rw_address == RVX_UART_TXBUF_THRESH_REG_ADDR;
  assign txbuf_irq = irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (thresh_wr) thresh_q <= write_data[7:0];
      irq_q <= enable_q && (32'(level) <= 32'(thresh_q));
    end
  end
`else
  assign txbuf_irq = 1'b0;
`endif

  always_comb begin
    read_data_d = '0;
    if (read_request) begin
      case (rw_address)
        RVX_UART_TXBUF_STATUS_REG_ADDR: read_data_d = txb_status(fifo_empty, fifo_full, overflow_q, 8'(level));
        RVX_UART_TXBUF_CTRL_REG_ADDR:   read_data_d = {31'h0, enable_q};
`ifdef RVX_UART_TXBUF_IRQ_EN
        RVX_UART_TXBUF_THRESH_REG_ADDR: read_data_d = {24'h0, thresh_q};
`endif
        default: read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= TXB_IDLE;
      tx_byte_q    <= '0;
      read_data_q  <= '0;
      read_resp_q  <= 1'b0;
      write_resp_q <= 1'b0;
      overflow_q   <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_byte_q    <= tx_byte_d;
      read_data_q  <= read_data_d;
      read_resp_q  <= read_request;
      write_resp_q <= write_request;
      if (data_wr && fifo_full)              overflow_q <= 1'b1;
      else if (status_wr && write_data[2])   overflow_q <= 1'b0;
      if (ctrl_wr) enable_q <= write_data[0];
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_resp_q;
  assign write_response = write_resp_q;

  // The head byte is captured when leaving WAIT_STATUS so it stays stable through WAIT_WRITE.
  always_comb begin
    state_d            = state_q;
    tx_byte_d          = tx_byte_q;
    uart_read_request  = 1'b0;
    uart_write_request = 1'b0;
    uart_rw_address    = '0;
    uart_write_data    = '0;
    case (state_q)
      TXB_IDLE: if (enable_q && !fifo_empty) state_d = TXB_POLL;
      TXB_POLL: begin
        uart_read_request = 1'b1;
        uart_rw_address   = RVX_UART_STATUS_REG_ADDR;
        state_d           = TXB_WAIT_STATUS;
      end
      TXB_WAIT_STATUS: begin
        uart_rw_address = RVX_UART_STATUS_REG_ADDR;
        if (uart_read_response) begin
          if (uart_read_data[0] && !fifo_empty && !flush) begin
            state_d   = TXB_WRITE;
            tx_byte_d = head;
          end else begin
            state_d = TXB_IDLE;
          end
        end
      end
      TXB_WRITE: begin
        uart_write_request = 1'b1;
        uart_rw_address    = RVX_UART_WRITE_REG_ADDR;
        uart_write_data    = {24'h0, tx_byte_q};
        state_d            = TXB_WAIT_WRITE;
      end
      TXB_WAIT_WRITE: begin
        uart_rw_address = RVX_UART_WRITE_REG_ADDR;
        uart_write_data = {24'h0, tx_byte_q};
        if (uart_write_response) state_d = TXB_IDLE;
      end
      default: state_d = TXB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvx_uart_tx_buffer.sv
// Directed bench for rvx_uart_tx_buffer; UART model answers reads two cycles and writes one cycle after the request.
module tb_rvx_uart_tx_buffer;

  localparam logic [4:0] A_DATA   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_CTRL   = 5'h08;
  localparam logic [4:0] A_THRESH = 5'h0C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rw_address = '0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [4:0]  uart_rw_address;
  logic [31:0] uart_read_data;
  logic        uart_read_request;
  logic        uart_read_response = 1'b0;
  logic [31:0] uart_write_data;
  logic        uart_write_request;
  logic        uart_write_response = 1'b0;
  logic        txbuf_irq;

  logic        uart_idle = 1'b1;
  logic        rd_d1 = 1'b0;
  int          poll_cnt = 0;
  logic [7:0]  wr_log[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  rvx_uart_tx_buffer dut (
    .clock               (clock),
    .reset               (reset),
    .rw_address          (rw_address),
    .read_data           (read_data),
    .read_request        (read_request),
    .read_response       (read_response),
    .write_data          (write_data),
    .write_request       (write_request),
    .write_response      (write_response),
    .uart_rw_address     (uart_rw_address),
    .uart_read_data      (uart_read_data),
    .uart_read_request   (uart_read_request),
    .uart_read_response  (uart_read_response),
    .uart_write_data     (uart_write_data),
    .uart_write_request  (uart_write_request),
    .uart_write_response (uart_write_response),
    .txbuf_irq           (txbuf_irq)
  );

  assign uart_read_data = {31'h0, uart_idle};

  always @(posedge clock) begin
    rd_d1               <= uart_read_request;
    uart_read_response  <= rd_d1;
    uart_write_response <= uart_write_request;
    if (uart_read_request)  poll_cnt <= poll_cnt + 1;
    if (uart_write_request) wr_log.push_back(uart_write_data[7:0]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    rw_address = a; write_data = d; write_request = 1'b1;
    tick();
    write_request = 1'b0; rw_address = '0; write_data = '0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    rw_address = a; read_request = 1'b1;
    tick();
    read_request = 1'b0; rw_address = '0;
    d = read_data;
  endtask

  task automatic wait_poll(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (uart_read_request) seen = 1'b1;
      else tick();
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int p0;
    logic done;

    // reset state
    tick(); tick();
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_strobes", {uart_read_request, uart_write_request, read_response, write_response}, 4'h0);
    chk("rst_uaddr", {uart_rw_address, uart_write_data}, 37'h0);
    chk("rst_irq", txbuf_irq, 1'b0);
    reset = 1'b0;
    tick();
    reg_read(A_STATUS, rd);
    chk("rst_status", rd, 32'h0000_0001);
    chk("rd_response", read_response, 1'b1);

    // single byte: write comes 3 cycles after the poll
    reg_write(A_CTRL, 32'h1);
    reg_write(A_DATA, 32'h141);
    wait_poll("t1_poll_seen");
    chk("t1_poll_addr", uart_rw_address, 5'h08);
    tick(); chk("t1_wr_p1", uart_write_request, 1'b0);
    tick(); chk("t1_wr_p2", uart_write_request, 1'b0);
    tick(); chk("t1_wr_p3", uart_write_request, 1'b1);
    chk("t1_wdata", uart_write_data, 32'h41);
    chk("t1_waddr", uart_rw_address, 5'h00);
    tick(); tick();
    reg_read(A_STATUS, rd);
    chk("t1_empty", rd, 32'h0000_0001);

    // busy UART: repeated polls, no writes, then in-order drain
    uart_idle = 1'b0;
    reg_write(A_DATA, 32'h10);
    reg_write(A_DATA, 32'h20);
    reg_write(A_DATA, 32'h30);
    p0 = poll_cnt;
    repeat (50) tick();
    chk("t2_polls", {31'h0, (poll_cnt - p0) >= 8}, 32'h1);
    chk("t2_no_wr", wr_log.size(), 1);
    reg_read(A_STATUS, rd);
    chk("t2_level3", rd, 32'h0000_0300);
    uart_idle = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (wr_log.size() >= 4) done = 1'b1;
      else tick();
    end
    chk("t2_drained", {31'h0, done}, 32'h1);
    chk("t2_b0", wr_log[1], 8'h10);
    chk("t2_b1", wr_log[2], 8'h20);
    chk("t2_b2", wr_log[3], 8'h30);
    repeat (4) tick();

    // overflow with drain disabled
    reg_write(A_CTRL, 32'h0);
    repeat (4) tick();
    for (int i = 0; i < 17; i++) reg_write(A_DATA, 32'h80 + i);
    reg_read(A_STATUS, rd);
    chk("t3_full_ovf", rd, 32'h0000_1006);
    reg_write(A_STATUS, 32'h4);
    reg_read(A_STATUS, rd);
    chk("t3_ovf_clr", rd, 32'h0000_1002);

    // push and pop together at level 16: push dropped
    reg_write(A_CTRL, 32'h1);
    wait_poll("t4_poll_full");
    repeat (3) tick();
    chk("t4_wr_full", uart_write_request, 1'b1);
    reg_write(A_DATA, 32'hAA);
    reg_write(A_CTRL, 32'h0);
    repeat (4) tick();
    reg_read(A_STATUS, rd);
    chk("t4_full_pp", rd, 32'h0000_0F04);
    chk("t4_sent_full", wr_log[wr_log.size()-1], 8'h80);

    // push and pop together at level 5: level unchanged
    reg_write(A_STATUS, 32'h4);
    reg_write(A_CTRL, 32'h2);
    reg_read(A_STATUS, rd);
    chk("t4_flushed", rd, 32'h0000_0001);
    for (int i = 0; i < 5; i++) reg_write(A_DATA, 32'h50 + i);
    reg_write(A_CTRL, 32'h1);
    wait_poll("t4_poll_5");
    repeat (3) tick();
    chk("t4_wr_5", uart_write_request, 1'b1);
    reg_write(A_DATA, 32'h55);
    reg_write(A_CTRL, 32'h0);
    repeat (4) tick();
    reg_read(A_STATUS, rd);
    chk("t4_level5", rd, 32'h0000_0500);
    chk("t4_sent_5", wr_log[wr_log.size()-1], 8'h50);

    // flush during WAIT_WRITE: latched byte still goes out, no further polls
    reg_write(A_CTRL, 32'h1);
    wait_poll("t5_poll");
    repeat (4) tick();
    chk("t5_ww_strobe", uart_write_request, 1'b0);
    chk("t5_ww_data", uart_write_data, 32'h51);
    reg_write(A_CTRL, 32'h3);
    p0 = poll_cnt;
    repeat (20) tick();
    chk("t5_no_polls", poll_cnt - p0, 0);
    chk("t5_sent", wr_log[wr_log.size()-1], 8'h51);
    chk("t5_idle_addr", uart_rw_address, 5'h00);
    reg_read(A_STATUS, rd);
    chk("t5_empty", rd, 32'h0000_0001);
    reg_read(A_CTRL, rd);
    chk("t5_ctrl", rd, 32'h0000_0001);

`ifdef RVX_UART_TXBUF_IRQ_EN
    // low watermark: irq rises the cycle after the level reaches 2
    reg_write(A_CTRL, 32'h0);
    reg_write(A_THRESH, 32'h2);
    reg_read(A_THRESH, rd);
    chk("t6_thresh", rd, 32'h2);
    uart_idle = 1'b0;
    for (int i = 0; i < 4; i++) reg_write(A_DATA, 32'hC0 + i);
    chk("t6_irq_dis", txbuf_irq, 1'b0);
    reg_write(A_CTRL, 32'h1);
    tick();
    chk("t6_irq_lvl4", txbuf_irq, 1'b0);
    uart_idle = 1'b1;
    p0 = 0;
    for (int i = 0; i < 60 && p0 < 2; i++) begin
      if (uart_write_request) p0++;
      if (p0 < 2) tick();
    end
    chk("t6_two_writes", p0, 2);
    tick();
    chk("t6_irq_lvl2_early", txbuf_irq, 1'b0);
    tick();
    chk("t6_irq_rise", txbuf_irq, 1'b1);
`else
    reg_write(A_THRESH, 32'h5);
    reg_read(A_THRESH, rd);
    chk("t6_thresh_off", rd, 32'h0);
    chk("t6_irq_off", txbuf_irq, 1'b0);
`endif

    // reset mid-transfer
    uart_idle = 1'b0;
    reg_write(A_CTRL, 32'h3);
    reg_write(A_DATA, 32'hE1);
    reg_write(A_DATA, 32'hE2);
    wait_poll("t7_poll");
    reset = 1'b1;
    tick();
    chk("t7_strobes", {uart_read_request, uart_write_request, read_response, write_response}, 4'h0);
    chk("t7_uaddr", uart_rw_address, 5'h00);
    chk("t7_irq", txbuf_irq, 1'b0);
    reset = 1'b0;
    tick();
    reg_read(A_STATUS, rd);
    chk("t7_lost", rd, 32'h0000_0001);
    p0 = poll_cnt;
    repeat (10) tick();
    chk("t7_quiet", poll_cnt - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
